mem_burst_responder: RTL and testbench

Main-memory-side responder for the output-stationary arbiter's memory interface. It accepts one command per transaction (address, read/write, burst length) from the arbiter and runs the burst data transfer with the granted PE core. Write bursts receive psums; read bursts supply config, weights and activations. It holds a word-addressed on-chip memory array and signals completion or error back to the arbiter.

---
 rtl/mem_burst_responder_if.sv | 31 +++
 rtl/mem_burst_responder.sv | 118 +++++++++++
 tb/tb_mem_burst_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_responder_if.sv
// Command and burst-data bundle between the arbiter/PE core (master) and the
// memory responder (slave).
interface mem_burst_responder_if #(
  parameter int unsigned MAIN_MEM_ADDR_WIDTH = 32,
  parameter int unsigned BURST_WIDTH         = 6,
  parameter int unsigned DATA_WIDTH          = 8
);
  logic                           w_start;
  logic [MAIN_MEM_ADDR_WIDTH-1:0] w_addr;
  logic                           w_rw;
  logic [BURST_WIDTH-1:0]         w_burst;
  logic [DATA_WIDTH-1:0]          w_wdata;
  logic                           w_wvalid;
  logic                           w_wready;
  logic [DATA_WIDTH-1:0]          w_rdata;
  logic                           w_rvalid;
  logic                           w_rready;
  logic                           w_busy;
  logic                           w_done;
  logic                           w_err;

  modport master (
    output w_start, w_addr, w_rw, w_burst, w_wdata, w_wvalid, w_rready,
    input  w_wready, w_rdata, w_rvalid, w_busy, w_done, w_err
  );

  modport slave (
    input  w_start, w_addr, w_rw, w_burst, w_wdata, w_wvalid, w_rready,
    output w_wready, w_rdata, w_rvalid, w_busy, w_done, w_err
  );
endinterface

// File: rtl/mem_burst_responder.sv
// Word-addressed on-chip memory that serves one read or write burst per
// command and reports completion, or a range error, back to the arbiter.
module mem_burst_responder #(
  parameter int unsigned MAIN_MEM_ADDR_WIDTH = 32,
  parameter int unsigned BURST_WIDTH         = 6,
  parameter int unsigned DATA_WIDTH          = 8,
  parameter int unsigned MEM_ADDR_BITS       = 10
) (
  input  logic                w_clock,
  input  logic                w_reset,
  mem_burst_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << MEM_ADDR_BITS;
  localparam int unsigned SUM_W = MAIN_MEM_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [MEM_ADDR_BITS-1:0] r_ptr;
  logic [BURST_WIDTH-1:0]   r_cnt;
  logic                     r_err;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_rvalid;
  logic [DATA_WIDTH-1:0]    r_mem [DEPTH];

  logic                     w_accept;
  logic [SUM_W-1:0]         w_end;
  logic                     w_range_err;
  logic                     w_zero;
  logic                     w_wbeat;
  logic                     w_rbeat;
  logic                     w_last;
  logic [MEM_ADDR_BITS-1:0] w_addr_lo;
  logic [MEM_ADDR_BITS-1:0] w_ptr_inc;

  // End address computed one bit wider so an overflowing burst cannot wrap into range.
  assign w_accept    = (r_state == IDLE) && bus.w_start;
  assign w_end       = SUM_W'(bus.w_addr) + SUM_W'(bus.w_burst);
  assign w_range_err = ((bus.w_addr >> MEM_ADDR_BITS) != '0) || (w_end > SUM_W'(DEPTH));
  assign w_zero      = (bus.w_burst == '0);
  assign w_wbeat     = (r_state == WRITE) && bus.w_wvalid;
  assign w_rbeat     = (r_state == READ) && r_rvalid && bus.w_rready;
  assign w_last      = (r_cnt <= BURST_WIDTH'(1));
  assign w_addr_lo   = bus.w_addr[MEM_ADDR_BITS-1:0];
  assign w_ptr_inc   = r_ptr + MEM_ADDR_BITS'(1);

  always_ff @(posedge w_clock) begin
    if (w_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_range_err || w_zero) w_state_nxt = DONE;
          else if (bus.w_rw)         w_state_nxt = WRITE;
          else                       w_state_nxt = READ;
        end
      end
      WRITE:   if (w_wbeat && w_last) w_state_nxt = DONE;
      READ:    if (w_rbeat && w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Burst pointer/count and the prefetched read beat.
  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ptr <= w_addr_lo;
        r_cnt <= bus.w_burst;
        r_err <= w_range_err;
        if (!w_range_err && !w_zero && !bus.w_rw) begin
          r_rdata  <= r_mem[w_addr_lo];
          r_rvalid <= 1'b1;
        end
      end
      if (w_wbeat) begin
        r_ptr <= w_ptr_inc;
        r_cnt <= r_cnt - BURST_WIDTH'(1);
      end
      if (w_rbeat) begin
        if (!w_last) begin
          r_rdata <= r_mem[w_ptr_inc];
          r_ptr   <= w_ptr_inc;
          r_cnt   <= r_cnt - BURST_WIDTH'(1);
        end else begin
          r_rvalid <= 1'b0;
        end
      end
      if (r_state == DONE) r_err <= 1'b0;
    end
  end

  // Array is never cleared; a beat coincident with reset is dropped.
  always_ff @(posedge w_clock) begin
    if (w_wbeat && !w_reset) r_mem[r_ptr] <= bus.w_wdata;
  end

  assign bus.w_wready = (r_state == WRITE);
  assign bus.w_busy   = (r_state != IDLE);
  assign bus.w_done   = (r_state == DONE);
  assign bus.w_err    = (r_state == DONE) && r_err;
  assign bus.w_rdata  = r_rdata;
  assign bus.w_rvalid = r_rvalid;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Randomized scoreboard bench for mem_burst_responder: a driver issues bursts
// and queues expectations from an array model, a negedge monitor checks them.
module tb_mem_burst_responder;

  localparam int unsigned AW    = 32;
  localparam int unsigned BW    = 6;
  localparam int unsigned DW    = 8;
  localparam int unsigned MB    = 10;
  localparam int unsigned DEPTH = 1 << MB;

  logic w_clock;
  logic w_reset;

  mem_burst_responder_if #(.MAIN_MEM_ADDR_WIDTH(AW), .BURST_WIDTH(BW), .DATA_WIDTH(DW)) bus();

  mem_burst_responder #(
    .MAIN_MEM_ADDR_WIDTH(AW), .BURST_WIDTH(BW), .DATA_WIDTH(DW), .MEM_ADDR_BITS(MB)
  ) dut (
    .w_clock (w_clock),
    .w_reset (w_reset),
    .bus     (bus)
  );

  typedef struct {bit err; int wb; int rb; int lat;} done_t;
  typedef struct {bit known; logic [7:0] d;} rd_t;

  done_t      exp_done[$];
  rd_t        exp_rd[$];
  logic [7:0] mdl   [DEPTH];
  bit         known [DEPTH];
  logic [7:0] wdata_q[$];
  bit         pat_q[$];

  int         n_checks;
  int         n_errors;
  int         cyc;
  int         c0;
  int         wb;
  int         rb;
  bit         prev_stall;
  logic [7:0] prev_data;
  rd_t        mon_r;
  done_t      mon_e;

  initial w_clock = 1'b0;
  always #5 w_clock = ~w_clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a read beat or done.
  always @(negedge w_clock) begin
    cyc++;
    if (w_reset) begin
      exp_done.delete();
      exp_rd.delete();
      prev_stall = 1'b0;
      wb = 0;
      rb = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_rvalid", 64'(bus.w_rvalid), 64'd1);
        chk("hold_rdata", 64'(bus.w_rdata), 64'(prev_data));
      end
      prev_stall = bus.w_rvalid && !bus.w_rready;
      prev_data  = bus.w_rdata;
      if (bus.w_wready && bus.w_wvalid) wb++;
      if (bus.w_rvalid && bus.w_rready) begin
        rb++;
        if (exp_rd.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL stray_read_beat: got %0h expected no beat", bus.w_rdata);
        end else begin
          mon_r = exp_rd.pop_front();
          if (mon_r.known) chk("read_data", 64'(bus.w_rdata), 64'(mon_r.d));
        end
      end
      if (bus.w_err) chk("err_with_done", 64'(bus.w_done), 64'd1);
      if (bus.w_done) begin
        if (exp_done.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 expected done=0");
        end else begin
          mon_e = exp_done.pop_front();
          chk("done_err", 64'(bus.w_err), 64'(mon_e.err));
          chk("write_beats", 64'(wb), 64'(mon_e.wb));
          chk("read_beats", 64'(rb), 64'(mon_e.rb));
          chk("done_latency", 64'(cyc - c0), 64'(mon_e.lat));
        end
      end
      if (bus.w_start && !bus.w_busy) begin
        c0 = cyc;
        wb = 0;
        rb = 0;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_rdata"},  64'(bus.w_rdata),  64'd0);
    chk({tag, "_rvalid"}, 64'(bus.w_rvalid), 64'd0);
    chk({tag, "_busy"},   64'(bus.w_busy),   64'd0);
    chk({tag, "_done"},   64'(bus.w_done),   64'd0);
    chk({tag, "_err"},    64'(bus.w_err),    64'd0);
    chk({tag, "_wready"}, 64'(bus.w_wready), 64'd0);
  endtask

  task automatic idle_inputs();
    bus.w_start  = 1'b0;
    bus.w_rw     = 1'b0;
    bus.w_addr   = '0;
    bus.w_burst  = '0;
    bus.w_wdata  = '0;
    bus.w_wvalid = 1'b0;
    bus.w_rready = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    @(posedge w_clock); #1;
    w_reset = 1'b1;
    idle_inputs();
    @(posedge w_clock);
    @(negedge w_clock);
    check_zero(tag);
    @(posedge w_clock); #1;
    w_reset = 1'b0;
  endtask

  // One transaction: expectations come from the array model and the
  // valid/ready pattern (beat p lands n-th accepted cycle; done one cycle later).
  task automatic do_txn(input bit rw, input logic [31:0] addr, input int n,
                        input int stall_pct, input bit poke);
    bit          err;
    bit          pat[$];
    bit          b;
    bit          ok;
    int          ones;
    int          beat;
    int unsigned a;
    logic [7:0]  d;
    done_t       e;
    rd_t         r;

    err  = (addr >= 32'(DEPTH)) || ((longint'(addr) + longint'(n)) > longint'(DEPTH));
    a    = 32'(addr[MB-1:0]);
    ones = 0;
    if (!err && n > 0) begin
      while (ones < n) begin
        if (pat_q.size() > 0) b = pat_q.pop_front();
        else                  b = ($urandom_range(0, 99) >= stall_pct);
        pat.push_back(b);
        if (b) ones++;
      end
    end
    pat_q.delete();

    if (!err && n > 0 && !rw) begin
      for (int i = 0; i < n; i++) begin
        r.known = known[a + i];
        r.d     = mdl[a + i];
        exp_rd.push_back(r);
      end
    end
    e.err = err;
    e.wb  = (!err && rw)  ? n : 0;
    e.rb  = (!err && !rw) ? n : 0;
    e.lat = (err || n == 0) ? 1 : pat.size() + 1;
    exp_done.push_back(e);

    @(posedge w_clock); #1;
    bus.w_start  = 1'b1;
    bus.w_rw     = rw;
    bus.w_addr   = addr;
    bus.w_burst  = BW'(n);
    bus.w_wvalid = 1'b0;
    bus.w_rready = 1'b0;

    if (err || n == 0) begin
      @(posedge w_clock); #1;
      bus.w_start  = 1'b0;
      bus.w_wvalid = 1'b1;
      bus.w_rready = 1'b1;
    end else begin
      beat = 0;
      foreach (pat[j]) begin
        @(posedge w_clock); #1;
        bus.w_start = poke && (j == 1);
        if (poke && j == 1) begin
          bus.w_rw    = 1'b0;
          bus.w_addr  = 32'h0;
          bus.w_burst = BW'(1);
        end
        if (rw) begin
          bus.w_wvalid = pat[j];
          if (pat[j]) begin
            d = (wdata_q.size() > 0) ? wdata_q.pop_front() : 8'($urandom);
            bus.w_wdata = d;
            mdl[a + beat]   = d;
            known[a + beat] = 1'b1;
            beat++;
          end else begin
            bus.w_wdata = 8'($urandom);
          end
        end else begin
          bus.w_rready = pat[j];
        end
      end
    end
    wdata_q.delete();

    @(posedge w_clock); #1;
    bus.w_start  = 1'b0;
    bus.w_wvalid = 1'b0;
    bus.w_rready = 1'b0;

    ok = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge w_clock);
      if (bus.w_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL txn_timeout: got busy=%0b expected idle within 8 cycles", bus.w_busy);
      apply_reset("recover");
    end
  endtask

  initial begin
    bit          rw;
    int          r;
    int          n;
    logic [31:0] addr;

    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    c0         = 0;
    wb         = 0;
    rb         = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mdl[i]   = 8'h00;
      known[i] = 1'b0;
    end
    w_reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge w_clock);
    @(negedge w_clock);
    check_zero("reset");
    @(posedge w_clock); #1;
    w_reset = 1'b0;

    // Write then read, then read with backpressure.
    wdata_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_txn(1'b1, 32'h010, 4, 0, 1'b0);
    do_txn(1'b0, 32'h010, 4, 0, 1'b0);
    pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_txn(1'b0, 32'h010, 3, 0, 1'b0);

    // Zero-length bursts leave memory untouched.
    do_txn(1'b0, 32'h010, 0, 0, 1'b0);
    do_txn(1'b1, 32'h010, 0, 0, 1'b0);
    do_txn(1'b0, 32'h010, 4, 0, 1'b0);

    // Range boundaries at the top of the array and just above it.
    wdata_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    do_txn(1'b1, 32'h3FC, 4, 0, 1'b0);
    wdata_q = '{8'hEE, 8'hEE, 8'hEE, 8'hEE};
    do_txn(1'b1, 32'h3FE, 4, 0, 1'b0);
    do_txn(1'b0, 32'h3FC, 4, 0, 1'b0);
    wdata_q = '{8'h11};
    do_txn(1'b1, 32'h000, 1, 0, 1'b0);
    wdata_q = '{8'h99};
    do_txn(1'b1, 32'h400, 1, 0, 1'b0);
    do_txn(1'b0, 32'h400, 1, 0, 1'b0);
    do_txn(1'b0, 32'h000, 1, 0, 1'b0);

    // Stalled write with an ignored start pulse mid-burst.
    wdata_q = '{8'hEE, 8'hEE, 8'hEE, 8'hEE};
    do_txn(1'b1, 32'h030, 4, 0, 1'b0);
    wdata_q = '{8'hB1, 8'hB2, 8'hB3};
    pat_q   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_txn(1'b1, 32'h030, 3, 0, 1'b1);
    do_txn(1'b0, 32'h030, 4, 0, 1'b0);

    // Reset after two beats of a four-beat write.
    wdata_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    do_txn(1'b1, 32'h020, 4, 0, 1'b0);
    @(posedge w_clock); #1;
    bus.w_start = 1'b1;
    bus.w_rw    = 1'b1;
    bus.w_addr  = 32'h020;
    bus.w_burst = BW'(4);
    for (int i = 0; i < 2; i++) begin
      @(posedge w_clock); #1;
      bus.w_start  = 1'b0;
      bus.w_wvalid = 1'b1;
      bus.w_wdata  = 8'h55;
      mdl[32 + i]  = 8'h55;
    end
    @(posedge w_clock); #1;
    w_reset = 1'b1;
    @(posedge w_clock);
    @(negedge w_clock);
    check_zero("midwrite_reset");
    @(posedge w_clock); #1;
    w_reset = 1'b0;
    idle_inputs();
    do_txn(1'b0, 32'h020, 4, 0, 1'b0);

    // Pre-fill the randomly targeted regions so read data is always known.
    do_txn(1'b1, 32'h000, 32, 0, 1'b0);
    do_txn(1'b1, 32'd32, 32, 0, 1'b0);
    do_txn(1'b1, 32'd1000, 24, 0, 1'b0);

    for (int k = 0; k < 80; k++) begin
      r  = $urandom_range(0, 9);
      rw = 1'($urandom_range(0, 1));
      if (r < 6) begin
        addr = 32'($urandom_range(0, 63));
        n    = $urandom_range(0, 12);
      end else if (r < 9) begin
        addr = 32'($urandom_range(1000, 1023));
        n    = $urandom_range(0, 30);
      end else begin
        addr = $urandom() | 32'h0000_0400;
        n    = $urandom_range(0, 63);
      end
      do_txn(rw, addr, n, 30, 1'($urandom_range(0, 3) == 0));
    end

    repeat (4) @(posedge w_clock);
    @(negedge w_clock);
    chk("pending_done", 64'(exp_done.size()), 64'd0);
    chk("pending_reads", 64'(exp_rd.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 5ms");
    $fatal(1, "bench timeout");
  end

endmodule
